// File: rtl/ifid_queue_pkg.sv
// Shared pipeline definitions: bubble encoding, datapath width, IF/ID entry layout
// and the flush-over-stall priority rule used by every pipeline register stage.
// No logic state; pure types, constants and one decode helper.
package ifid_queue_pkg;

  localparam int XLEN = 32;

  // addi x0,x0,0 : the architectural bubble injected on flush and reset
  localparam logic [XLEN-1:0] NOP_INST = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } ifid_entry_t;

  typedef enum logic [1:0] {
    ACT_ADVANCE = 2'd0,
    ACT_STALL   = 2'd1,
    ACT_FLUSH   = 2'd2
  } pipe_act_e;

  // A redirect always beats a downstream stall: wrong-path state must never be held.
  function automatic pipe_act_e pipe_action(input logic flush, input logic stall);
    if (flush) return ACT_FLUSH;
    if (stall) return ACT_STALL;
    return ACT_ADVANCE;
  endfunction

endpackage

// File: rtl/ifid_queue_fifo.sv
// Circular buffer of {pc,inst} entries with simultaneous push/pop and synchronous clear.
// Latency: write visible at dout one edge after push into an empty buffer; dout is the head, combinational.
// Backpressure: none internally; the caller must not push when full unless it also pops.
module ifid_fifo
  import ifid_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  ifid_entry_t                din,
  output ifid_entry_t                dout,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  ifid_entry_t   mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;

  assign dout = mem[head];

  // Storage array; contents are only meaningful below count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[tail] <= din;
    end
  end

  // Pointers and occupancy; power-of-two depth lets the pointers wrap on their own.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/ifid_queue.sv
// IF->ID pipeline register with a skid FIFO absorbing ID stalls and dropping wrong-path words on redirect.
// Latency: 1 cycle when the FIFO is empty, 1 + count cycles otherwise.
// Backpressure: IF cannot be stalled; ID stall fills the FIFO, words arriving while full are dropped and flagged.
module ifid_queue
  import ifid_queue_pkg::*;
#(
  parameter int              DEPTH = 4,
  parameter logic [XLEN-1:0] NOP   = NOP_INST
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] IFID_d_inst,
  input  logic [XLEN-1:0] IFID_d_pc,
  input  logic            EXMEM_c_SelPC,
  input  logic            ID_c_stall,
  output logic [XLEN-1:0] ID_d_inst,
  output logic [XLEN-1:0] ID_d_pc,
  output logic            ID_c_valid,
  output logic            IF_c_full,
  output logic            ERR_c_overflow
);

  localparam int CW = $clog2(DEPTH) + 1;

  pipe_act_e       act;
  ifid_entry_t     if_entry;
  ifid_entry_t     fifo_dout;
  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  logic            fifo_full;
  logic            push;
  logic            pop;
  logic            clear;
  logic            drop;

  assign if_entry   = '{pc: IFID_d_pc, inst: IFID_d_inst};
  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == CW'(DEPTH));
  assign IF_c_full  = fifo_full;

  // Decide this edge's action and the FIFO push/pop that realise it.
  always_comb begin
    act   = pipe_action(EXMEM_c_SelPC, ID_c_stall);
    push  = 1'b0;
    pop   = 1'b0;
    drop  = 1'b0;
    clear = 1'b0;
    case (act)
      ACT_FLUSH: clear = 1'b1;
      ACT_STALL: begin
        push = !fifo_full;
        drop = fifo_full;
      end
      default: begin
        // Non-empty: head leaves, incoming joins the tail, occupancy unchanged.
        // Empty: incoming bypasses straight to the output register.
        pop  = !fifo_empty;
        push = !fifo_empty;
      end
    endcase
  end

  ifid_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (clear),
    .din   (if_entry),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  // Output register to ID: bubble on flush, hold on stall, head-or-bypass on advance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ID_d_inst  <= NOP;
      ID_d_pc    <= '0;
      ID_c_valid <= 1'b0;
    end else begin
      case (act)
        ACT_FLUSH: begin
          ID_d_inst  <= NOP;
          ID_d_pc    <= '0;
          ID_c_valid <= 1'b0;
        end
        ACT_STALL: begin
          ID_d_inst  <= ID_d_inst;
          ID_d_pc    <= ID_d_pc;
          ID_c_valid <= ID_c_valid;
        end
        default: begin
          if (fifo_empty) begin
            ID_d_inst <= IFID_d_inst;
            ID_d_pc   <= IFID_d_pc;
          end else begin
            ID_d_inst <= fifo_dout.inst;
            ID_d_pc   <= fifo_dout.pc;
          end
          ID_c_valid <= 1'b1;
        end
      endcase
    end
  end

  // Sticky overflow flag; only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ERR_c_overflow <= 1'b0;
    end else if (drop) begin
      ERR_c_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ifid_queue.sv
module tb_ifid_queue;

  logic        clk;
  logic        rst;
  logic [31:0] IFID_d_inst;
  logic [31:0] IFID_d_pc;
  logic        EXMEM_c_SelPC;
  logic        ID_c_stall;
  logic [31:0] ID_d_inst;
  logic [31:0] ID_d_pc;
  logic        ID_c_valid;
  logic        IF_c_full;
  logic        ERR_c_overflow;

  int checks;
  int errors;

  logic [31:0] if_pc;
  logic [31:0] target;

  ifid_queue #(.DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .IFID_d_inst    (IFID_d_inst),
    .IFID_d_pc      (IFID_d_pc),
    .EXMEM_c_SelPC  (EXMEM_c_SelPC),
    .ID_c_stall     (ID_c_stall),
    .ID_d_inst      (ID_d_inst),
    .ID_d_pc        (ID_d_pc),
    .ID_c_valid     (ID_c_valid),
    .IF_c_full      (IF_c_full),
    .ERR_c_overflow (ERR_c_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction word tagged by its PC so reordering or stale data is visible.
  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  task automatic drive_if();
    IFID_d_pc   = if_pc;
    IFID_d_inst = inst_of(if_pc);
  endtask

  // One clock: the DUT samples the current IF word; then IF moves to the next PC.
  task automatic tick();
    logic redirect;
    redirect = EXMEM_c_SelPC;
    @(posedge clk);
    #1;
    if (redirect) if_pc = target;
    else          if_pc = if_pc + 32'd4;
    drive_if();
  endtask

  task automatic do_reset();
    rst           = 1'b0;
    EXMEM_c_SelPC = 1'b0;
    ID_c_stall    = 1'b0;
    target        = 32'h0;
    if_pc         = 32'h0;
    drive_if();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst           = 1'b0;
    EXMEM_c_SelPC = 1'b0;
    ID_c_stall    = 1'b0;
    if_pc         = 32'h0;
    drive_if();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ID_d_inst !== 32'h13) begin errors++; $display("FAIL rst_inst got %h exp %h", ID_d_inst, 32'h13); end
    checks++; if (ID_d_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", ID_d_pc); end
    checks++; if (ID_c_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", ID_c_valid); end
    checks++; if (IF_c_full !== 1'b0 || ERR_c_overflow !== 1'b0) begin errors++; $display("FAIL rst_flags got full=%b err=%b exp 0 0", IF_c_full, ERR_c_overflow); end
    checks++; if (dut.u_fifo.count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", dut.u_fifo.count); end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ID_d_pc !== 32'(4 * i) || ID_c_valid !== 1'b1 || ID_d_inst !== inst_of(32'(4 * i))) begin
        errors++; $display("FAIL stream_%0d got pc=%h v=%b inst=%h exp pc=%h v=1", i, ID_d_pc, ID_c_valid, ID_d_inst, 32'(4 * i));
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc;
    do_reset();
    tick(); tick();                  // output pc 4, IF now presents 8
    ID_c_stall = 1'b1;
    tick(); tick();                  // 8 and 12 queued
    checks++; if (ID_d_pc !== 32'h4 || ID_c_valid !== 1'b1) begin errors++; $display("FAIL stall_hold got pc=%h v=%b exp pc=4 v=1", ID_d_pc, ID_c_valid); end
    checks++; if (dut.u_fifo.count !== 3'd2) begin errors++; $display("FAIL stall_count got %0d exp 2", dut.u_fifo.count); end
    ID_c_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_pc = 32'(8 + 4 * i);
      checks++;
      if (ID_d_pc !== exp_pc || ID_d_inst !== inst_of(exp_pc) || ID_c_valid !== 1'b1) begin
        errors++; $display("FAIL drain_%0d got pc=%h inst=%h exp pc=%h", i, ID_d_pc, ID_d_inst, exp_pc);
      end
      checks++; if (dut.u_fifo.count !== 3'd2) begin errors++; $display("FAIL drain_count_%0d got %0d exp 2", i, dut.u_fifo.count); end
    end
    checks++; if (ERR_c_overflow !== 1'b0 || IF_c_full !== 1'b0) begin errors++; $display("FAIL stall_flags got err=%b full=%b exp 0 0", ERR_c_overflow, IF_c_full); end
  endtask

  task automatic test_overflow();
    logic [31:0] exp_seq [5];
    exp_seq = '{32'h4, 32'h8, 32'hC, 32'h10, 32'h1C};
    do_reset();
    tick();                          // output pc 0, IF presents 4
    ID_c_stall = 1'b1;
    repeat (3) tick();
    checks++; if (IF_c_full !== 1'b0) begin errors++; $display("FAIL full_early got %b exp 0", IF_c_full); end
    tick();
    checks++; if (IF_c_full !== 1'b1 || ERR_c_overflow !== 1'b0) begin errors++; $display("FAIL full_at4 got full=%b err=%b exp 1 0", IF_c_full, ERR_c_overflow); end
    tick(); tick();                  // pcs 20 and 24 dropped
    checks++; if (ERR_c_overflow !== 1'b1 || ID_d_pc !== 32'h0) begin errors++; $display("FAIL overflow got err=%b pc=%h exp err=1 pc=0", ERR_c_overflow, ID_d_pc); end
    ID_c_stall = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (ID_d_pc !== exp_seq[i] || ID_d_inst !== inst_of(exp_seq[i]) || ID_c_valid !== 1'b1) begin
        errors++; $display("FAIL ovf_drain_%0d got pc=%h exp %h", i, ID_d_pc, exp_seq[i]);
      end
    end
    checks++; if (ERR_c_overflow !== 1'b1 || IF_c_full !== 1'b1) begin errors++; $display("FAIL ovf_sticky got err=%b full=%b exp 1 1", ERR_c_overflow, IF_c_full); end
  endtask

  task automatic test_redirect();
    do_reset();
    tick();                          // output 0, IF presents 4
    ID_c_stall = 1'b1;
    repeat (3) tick();               // 4, 8, 12 queued
    checks++; if (dut.u_fifo.count !== 3'd3) begin errors++; $display("FAIL redir_pre_count got %0d exp 3", dut.u_fifo.count); end
    ID_c_stall    = 1'b0;
    EXMEM_c_SelPC = 1'b1;
    target        = 32'h100;
    tick();
    EXMEM_c_SelPC = 1'b0;
    checks++;
    if (ID_c_valid !== 1'b0 || ID_d_inst !== 32'h13 || ID_d_pc !== 32'h0 || dut.u_fifo.count !== 3'd0) begin
      errors++; $display("FAIL redir_flush got v=%b inst=%h pc=%h cnt=%0d exp v=0 inst=13 pc=0 cnt=0", ID_c_valid, ID_d_inst, ID_d_pc, dut.u_fifo.count);
    end
    tick();
    checks++; if (ID_d_pc !== 32'h100 || ID_c_valid !== 1'b1 || ID_d_inst !== inst_of(32'h100)) begin errors++; $display("FAIL redir_target got pc=%h v=%b exp pc=100 v=1", ID_d_pc, ID_c_valid); end
    tick();
    checks++; if (ID_d_pc !== 32'h104 || ID_c_valid !== 1'b1) begin errors++; $display("FAIL redir_next got pc=%h v=%b exp pc=104 v=1", ID_d_pc, ID_c_valid); end
  endtask

  task automatic test_flush_vs_stall();
    do_reset();
    tick();
    ID_c_stall = 1'b1;
    tick(); tick();
    EXMEM_c_SelPC = 1'b1;
    target        = 32'h200;
    tick();
    EXMEM_c_SelPC = 1'b0;
    ID_c_stall    = 1'b0;
    checks++;
    if (ID_c_valid !== 1'b0 || ID_d_inst !== 32'h13 || dut.u_fifo.count !== 3'd0) begin
      errors++; $display("FAIL flush_wins got v=%b inst=%h cnt=%0d exp v=0 inst=13 cnt=0", ID_c_valid, ID_d_inst, dut.u_fifo.count);
    end
    tick();
    checks++; if (ID_d_pc !== 32'h200 || ID_c_valid !== 1'b1) begin errors++; $display("FAIL flush_wins_target got pc=%h v=%b exp pc=200 v=1", ID_d_pc, ID_c_valid); end
  endtask

  task automatic test_async_reset();
    do_reset();
    tick(); tick();                  // output 4, IF presents 8
    ID_c_stall = 1'b1;
    tick(); tick();
    ID_c_stall = 1'b0;
    tick();                          // draining: output 8, count 2
    checks++; if (ID_d_pc !== 32'h8 || dut.u_fifo.count !== 3'd2) begin errors++; $display("FAIL pre_arst got pc=%h cnt=%0d exp pc=8 cnt=2", ID_d_pc, dut.u_fifo.count); end
    #2;
    rst = 1'b0;
    #1;                              // still well before the next rising edge
    checks++;
    if (ID_d_inst !== 32'h13 || ID_d_pc !== 32'h0 || ID_c_valid !== 1'b0 || dut.u_fifo.count !== 3'd0) begin
      errors++; $display("FAIL arst got inst=%h pc=%h v=%b cnt=%0d exp inst=13 pc=0 v=0 cnt=0", ID_d_inst, ID_d_pc, ID_c_valid, dut.u_fifo.count);
    end
    @(posedge clk);
    #1;
    if_pc = 32'h0;
    drive_if();
    rst = 1'b1;
    tick();
    checks++; if (ID_d_pc !== 32'h0 || ID_c_valid !== 1'b1 || dut.u_fifo.count !== 3'd0) begin errors++; $display("FAIL post_arst got pc=%h v=%b cnt=%0d exp pc=0 v=1 cnt=0", ID_d_pc, ID_c_valid, dut.u_fifo.count); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b0;
    EXMEM_c_SelPC = 1'b0;
    ID_c_stall    = 1'b0;
    target        = 32'h0;
    if_pc         = 32'h0;
    drive_if();
    #1;
    test_reset();
    test_stall();
    test_overflow();
    test_redirect();
    test_flush_vs_stall();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifid_queue.md
# ifid_queue

Fetch-to-decode receiver sitting between the IF stage and ID. Every cycle, IF presents the fetched word and its PC, and IF has no stall input. This block registers that pair for ID, absorbs ID stalls in a small FIFO so no fetched instruction is lost, and discards wrong-path instructions when EXMEM redirects the PC. It produces the valid/bubble qualification that ID and the hazard logic consume.

## Interface
- DEPTH, 4: skid FIFO entries; power of two, ≥2.
- NOP, 32'h00000013: bubble encoding (addi x0,x0,0) driven on flush/reset.

- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- IFID_d_inst  in  32  fetched instruction from IF; valid every cycle while rst=1.
- IFID_d_pc  in  32  PC of IFID_d_inst.
- EXMEM_c_SelPC  in  1  redirect taken in EX/MEM; the IF PC loads the target on this edge.
- ID_c_stall  in  1  ID cannot accept a new instruction this cycle.
- ID_d_inst  out  32  registered instruction to ID.
- ID_d_pc  out  32  registered PC to ID.
- ID_c_valid  out  1  ID_d_inst is a real, right-path instruction.
- IF_c_full  out  1  FIFO holds DEPTH entries (combinational from count); reserved for a future IF stall port.
- ERR_c_overflow  out  1  sticky; an instruction was dropped because the FIFO was full.

## Operation
- Reset (rst=0, async):
  - ID_d_inst=NOP, ID_d_pc=0, ID_c_valid=0.
  - FIFO empty, with head, tail and count at 0.
  - ERR_c_overflow=0.
- Each rising edge while rst=1, evaluate in priority order:
  1. Flush (EXMEM_c_SelPC=1):
     - Empty the FIFO: pointers and count to 0.
     - Do not enqueue the incoming word; it is wrong-path.
     - Drive ID_d_inst=NOP, ID_d_pc=0, ID_c_valid=0.
     - Flush overrides ID_c_stall.
  2. Stall (ID_c_stall=1):
     - Output register holds.
     - Incoming word is enqueued at tail if count<DEPTH.
     - Otherwise the incoming word is dropped and ERR_c_overflow is set.
  3. Advance (neither flush nor stall):
     - If count>0: the head entry goes to the output with ID_c_valid=1, and the incoming word is enqueued in the same edge, so count is unchanged.
     - If count=0: the incoming word bypasses to the output with ID_c_valid=1.
- Order: the output sequence always equals the IF fetch sequence minus flushed words. No reordering and no duplication.
- Pointers are log2(DEPTH) bits and wrap naturally.
- Count is log2(DEPTH)+1 bits, range 0..DEPTH.
- ERR_c_overflow clears only on reset.

## Timing
- Latency IF→ID: 1 cycle when the FIFO is empty; 1 + count cycles otherwise.
- First edge after reset release: ID_d_pc=0, ID_c_valid=1.
- Redirect edge: ID_c_valid=0.
  - Next edge: the output is the jump target, from IF, via bypass.
  - Exactly one bubble is visible at ID per redirect.
- A stall of N cycles (N≤DEPTH) grows count by N.
  - Each subsequent non-stall cycle drains one entry.
  - Count never shrinks while IF keeps fetching, because dequeue and enqueue coincide; only a flush empties it.
- IF_c_full rises in the same cycle count reaches DEPTH.
- Reset asserted mid-stall or mid-drain: all state returns to reset values immediately. No partial entries survive.

## Structure
- Shared header (the pipeline defines include): the NOP encoding constant, XLEN=32, and the flush-priority convention, reused by the ID/EX and EX/MEM registers.
- One sub-module, ifid_fifo: a DEPTH×64 {pc,inst} circular buffer.
  - Ports: clk, rst, push, pop, clear, din, dout, count.
  - Supports simultaneous push+pop.
- The parent holds the output register and the priority logic.

## Test plan
- Reset then release, with IF streaming pc 0,4,8: the following edges give ID_d_pc 0,4,8 with ID_c_valid=1. During reset: ID_d_inst=32'h13, valid=0.
- Stall 2 cycles while IF presents pc 8 and 12:
  - Output holds pc 4 and count reaches 2.
  - After release, the outputs are 8, 12, 16, …, each 2 cycles late.
  - ERR_c_overflow stays 0.
- Stall 6 cycles with DEPTH=4:
  - IF_c_full=1 after 4 stall cycles.
  - pcs of the 5th and 6th stalled fetches are dropped and ERR_c_overflow=1.
  - The drain shows exactly the first 4 queued pcs in order.
- Redirect with count=3 and target 0x100:
  - Flush edge: valid=0, ID_d_inst=NOP, count=0.
  - Next edge: ID_d_pc=0x100, valid=1.
- EXMEM_c_SelPC=1 and ID_c_stall=1 on the same edge: the flush wins, giving an empty FIFO and a bubble output.
- Assert rst asynchronously mid-drain with count=2: outputs go to reset values before the next clock edge, and count=0.
